rtl_unpack_datx4: RTL and testbench
===================================

RTL_UNPACK_DATX4 -- requirements
Module: rtl_unpack_datx4

Purpose: downstream of the x4 word packer; splits each 4-word beat back into single words, with backpressure.

Interface
REQ-001 SHALL have parameter WID, default 32: bits per word.
REQ-002 SHALL have parameter NOB, default 2: width of the byte-count field of one word.
REQ-003 SHALL have parameter INF, default 1: sideband info width.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, all state on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port idat, input, WID*4 bits: packed beat, left-aligned; word k is idat[WID*(4-k)-1 -: WID].
REQ-007 SHALL have port ivld, input, 1 bit: beat valid.
REQ-008 SHALL have port isop, input, 1 bit: beat starts a packet.
REQ-009 SHALL have port ieop, input, 1 bit: beat ends a packet.
REQ-010 SHALL have port iinf, input, INF bits: per-beat sideband.
REQ-011 SHALL have port inob, input, NOB+2 bits: {last word index 0..3, byte count of last word}.
REQ-012 SHALL have port irdy, output, 1 bit: beat accepted when ivld & irdy.
REQ-013 SHALL have port odat, output, WID bits: output word.
REQ-014 SHALL have port ovld, output, 1 bit: word valid.
REQ-015 SHALL have port osop, output, 1 bit: first word of packet.
REQ-016 SHALL have port oeop, output, 1 bit: last word of packet.
REQ-017 SHALL have port oinf, output, INF bits: sideband of the originating beat.
REQ-018 SHALL have port onob, output, NOB bits: byte count of the word.
REQ-019 SHALL have port ordy, input, 1 bit: word consumed when ovld & ordy.

Function
REQ-020 SHALL hold one beat in a register (data, sop, eop, inf, last index L, last byte count) plus a 2-bit word counter cnt and a busy flag.
REQ-021 SHALL use two states: IDLE (busy=0) and SEND (busy=1); IDLE->SEND on accept; SEND->IDLE on the transfer with cnt==L if no new beat is accepted on that cycle.
REQ-022 SHALL drive irdy = ~busy | (ovld & ordy & cnt==L), combinationally, so beats stream back-to-back with no bubble.
REQ-023 SHALL present the first word of an accepted beat one cycle after the accept edge (latency 1), with cnt=0.
REQ-024 SHALL drive ovld = busy, and odat = held word cnt.
REQ-025 SHALL increment cnt on each ovld & ordy while cnt<L; SHALL load cnt=0 on accept.
REQ-026 SHALL emit exactly L+1 words per beat; the words above index L are discarded.
REQ-027 SHALL drive osop = ovld & held sop & cnt==0.
REQ-028 SHALL drive oeop = ovld & held eop & cnt==L.
REQ-029 SHALL drive onob = held last byte count when cnt==L, else all ones.
REQ-030 SHALL hold oinf constant for every word of a beat.
REQ-031 SHALL hold odat, osop, oeop, oinf and onob stable while ovld & ~ordy.
REQ-032 SHALL treat a non-eop beat with L<3 the same as any other beat and emit L+1 words; no error is flagged.
REQ-033 SHALL ignore idat, isop, ieop, iinf and inob when ivld & irdy is false.

Reset
REQ-034 SHALL, while rst=0, force busy=0 and cnt=0, and clear all held fields to 0.
REQ-035 SHALL therefore drive, in reset: ovld=0, osop=0, oeop=0, odat=0, onob=0, oinf=0, irdy=1.
REQ-036 SHALL discard a partially sent beat if reset is asserted mid-beat; the first accept after release restarts at cnt=0.

Verification
REQ-037 SHALL pass: one beat, WID=32, idat=0x11111111_22222222_33333333_44444444, isop=ieop=1, inob=4'b1110, ordy=1 -> 4 words 0x11111111..0x44444444 on consecutive cycles starting 1 cycle after accept; osop on word 0; oeop on word 3; onob=3,3,3,2.
REQ-038 SHALL pass: eop beat with inob=4'b0101 -> 2 words, oeop and onob=1 on word 1, irdy=1 during word 1.
REQ-039 SHALL pass: three full beats back-to-back with ordy=1 -> 12 contiguous words, ovld never drops, irdy high only on every 4th cycle.
REQ-040 SHALL pass: ordy=0 for 5 cycles at word 2 -> odat, onob and oinf frozen; irdy=0; the sequence resumes unchanged.
REQ-041 SHALL pass: rst asserted after word 1 of 4 -> ovld=0 immediately (asynchronous); the next beat after release starts at word 0 with osop set.
REQ-042 SHALL pass: single-word eop beat inob=4'b0011 -> 1 word with osop=oeop=1, onob=3.

Source files
------------

// File: rtl/rtl_unpack_datx4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rtl_unpack_datx4 : splits each packed 4-word beat into single words       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rtl_unpack_datx4 #(
    parameter int WID = 32,
    parameter int NOB = 2,
    parameter int INF = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WID*4-1:0]   idat,
    input  logic               ivld,
    input  logic               isop,
    input  logic               ieop,
    input  logic [INF-1:0]     iinf,
    input  logic [NOB+1:0]     inob,
    output logic               irdy,
    output logic [WID-1:0]     odat,
    output logic               ovld,
    output logic               osop,
    output logic               oeop,
    output logic [INF-1:0]     oinf,
    output logic [NOB-1:0]     onob,
    input  logic               ordy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         lst_q, lst_d;
    logic [WID*4-1:0]   dat_q, dat_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [INF-1:0]     inf_q, inf_d;
    logic [NOB-1:0]     nob_q, nob_d;

    logic               w_busy;
    logic               w_xfer;
    logic               w_last;
    logic               w_acc;
    logic [WID-1:0]     w_word [4];

    // Word k sits left-aligned in the beat: word 0 occupies the top bits.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_word
            assign w_word[k] = dat_q[WID*(4-k)-1 -: WID];
        end
    endgenerate

    assign w_busy = (state_q == S_SEND);
    assign w_xfer = w_busy & ordy;
    assign w_last = (cnt_q == lst_q);
    // Accept a new beat in the same cycle the final word leaves, so beats stream without a bubble.
    assign irdy   = ~w_busy | (w_xfer & w_last);
    assign w_acc  = ivld & irdy;

    assign ovld = w_busy;
    assign odat = w_word[cnt_q];
    assign osop = w_busy & sop_q & (cnt_q == 2'd0);
    assign oeop = w_busy & eop_q & w_last;
    assign oinf = inf_q;
    assign onob = w_last ? nob_q : {NOB{1'b1}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lst_d   = lst_q;
        dat_d   = dat_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        inf_d   = inf_q;
        nob_d   = nob_q;
        if (w_acc) begin
            state_d = S_SEND;
            cnt_d   = 2'd0;
            lst_d   = inob[NOB+1:NOB];
            dat_d   = idat;
            sop_d   = isop;
            eop_d   = ieop;
            inf_d   = iinf;
            nob_d   = inob[NOB-1:0];
        end else if (w_xfer) begin
            if (w_last) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            lst_q   <= 2'd0;
            dat_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            inf_q   <= '0;
            nob_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lst_q   <= lst_d;
            dat_q   <= dat_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            inf_q   <= inf_d;
            nob_q   <= nob_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtl_unpack_datx4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rtl_unpack_datx4 : bench for the x4 word unpacker                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rtl_unpack_datx4;

    typedef struct {
        logic [31:0] dat;
        logic        sop;
        logic        eop;
        logic        inf;
        logic [1:0]  nob;
    } wrd_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] idat = '0;
    logic         ivld = 1'b0;
    logic         isop = 1'b0;
    logic         ieop = 1'b0;
    logic [0:0]   iinf = '0;
    logic [3:0]   inob = '0;
    logic         irdy;
    logic [31:0]  odat;
    logic         ovld;
    logic         osop;
    logic         oeop;
    logic [0:0]   oinf;
    logic [1:0]   onob;
    logic         ordy = 1'b1;

    int checks = 0;
    int errors = 0;
    wrd_t exp_q[$];
    wrd_t log_q[$];

    rtl_unpack_datx4 #(.WID(32), .NOB(2), .INF(1)) dut (
        .clk (clk),  .rst (rst),
        .idat(idat), .ivld(ivld), .isop(isop), .ieop(ieop),
        .iinf(iinf), .inob(inob), .irdy(irdy),
        .odat(odat), .ovld(ovld), .osop(osop), .oeop(oeop),
        .oinf(oinf), .onob(onob), .ordy(ordy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each accepted beat becomes L+1 expected words in a queue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ovld", ovld, 0); chk("rst_irdy", irdy, 1);
            chk("rst_odat", odat, 0); chk("rst_onob", onob, 0);
            chk("rst_oinf", oinf, 0); chk("rst_osop", osop, 0);
            chk("rst_oeop", oeop, 0);
            exp_q.delete();
        end else begin
            chk("ovld", ovld, exp_q.size() != 0);
            chk("irdy", irdy, (exp_q.size() == 0) || (exp_q.size() == 1 && ordy));
            if (ovld && exp_q.size() != 0) begin
                chk("odat", odat, exp_q[0].dat);
                chk("osop", osop, exp_q[0].sop);
                chk("oeop", oeop, exp_q[0].eop);
                chk("oinf", oinf, exp_q[0].inf);
                chk("onob", onob, exp_q[0].nob);
            end
            if (ovld && ordy) begin
                log_q.push_back('{odat, osop, oeop, oinf[0], onob});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (ivld && irdy) begin
                int L;
                L = int'(inob[3:2]);
                for (int k = 0; k <= L; k++) begin
                    wrd_t w;
                    w.dat = 32'(idat >> (32 * (3 - k)));
                    w.sop = isop && (k == 0);
                    w.eop = ieop && (k == L);
                    w.inf = iinf[0];
                    w.nob = (k == L) ? inob[1:0] : 2'b11;
                    exp_q.push_back(w);
                end
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic s, input logic e, input logic [3:0] n);
        int  cyc = 0;
        logic acc;
        idat = d; isop = s; ieop = e; inob = n; iinf = 1'b1; ivld = 1'b1;
        do begin
            @(negedge clk); acc = irdy;
            @(posedge clk); #1; cyc++;
        end while (!acc && cyc < 200);
        if (!acc) chk("send_timeout", 0, 1);
        ivld = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        ordy = 1'b1;
        while (ovld && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (ovld) chk("drain_timeout", 0, 1);
    endtask

    localparam logic [127:0] BEAT = 128'h11111111_22222222_33333333_44444444;

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        // Four words, first one visible right after the accept edge.
        log_q.delete();
        send(BEAT, 1, 1, 4'b1110);
        chk("lat_ovld", ovld, 1); chk("lat_odat", odat, 32'h11111111);
        drain();
        chk("b4_cnt", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("b4_w0", log_q[0].dat, 32'h11111111); chk("b4_w3", log_q[3].dat, 32'h44444444);
            chk("b4_sop0", log_q[0].sop, 1); chk("b4_sop1", log_q[1].sop, 0);
            chk("b4_eop2", log_q[2].eop, 0); chk("b4_eop3", log_q[3].eop, 1);
            chk("b4_nob", {log_q[0].nob, log_q[1].nob, log_q[2].nob, log_q[3].nob}, 8'b11_11_11_10);
        end

        // Two-word eop beat.
        log_q.delete();
        send(BEAT, 0, 1, 4'b0101);
        @(posedge clk); #1;
        chk("b2_irdy_w1", irdy, 1);
        drain();
        chk("b2_cnt", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("b2_w1", log_q[1].dat, 32'h22222222); chk("b2_eop", log_q[1].eop, 1);
            chk("b2_nob", log_q[1].nob, 1); chk("b2_nob0", log_q[0].nob, 3);
        end

        // Single-word beat.
        log_q.delete();
        send(BEAT, 1, 1, 4'b0011);
        drain();
        chk("b1_cnt", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("b1_sop", log_q[0].sop, 1); chk("b1_eop", log_q[0].eop, 1);
            chk("b1_nob", log_q[0].nob, 3); chk("b1_w0", log_q[0].dat, 32'h11111111);
        end

        // Three full beats back to back.
        log_q.delete();
        send(BEAT, 1, 0, 4'b1111);
        send(~BEAT, 0, 0, 4'b1111);
        send(BEAT ^ 128'h5, 0, 1, 4'b1100);
        drain();
        chk("b3x_cnt", log_q.size(), 12);
        if (log_q.size() == 12) begin
            chk("b3x_w4", log_q[4].dat, 32'heeeeeeee); chk("b3x_w11", log_q[11].dat, 32'h44444441);
        end

        // Stall at word 2 for five cycles.
        log_q.delete();
        send(BEAT, 1, 1, 4'b1110);
        repeat (2) begin @(posedge clk); #1; end
        ordy = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("stall_odat", odat, 32'h33333333); chk("stall_irdy", irdy, 0);
        chk("stall_onob", onob, 3);
        drain();
        chk("stall_cnt", log_q.size(), 4);

        // Asynchronous reset mid-beat.
        send(BEAT, 1, 1, 4'b1110);
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("arst_ovld", ovld, 0); chk("arst_irdy", irdy, 1);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        send(~BEAT, 1, 1, 4'b1110);
        chk("arst_osop", osop, 1); chk("arst_odat", odat, 32'heeeeeeee);
        drain();

        // Randomized traffic checked by the model.
        for (int c = 0; c < 2000; c++) begin
            ivld = ($urandom % 3) != 0;
            idat = {$urandom, $urandom, $urandom, $urandom};
            isop = 1'($urandom); ieop = 1'($urandom);
            iinf = 1'($urandom); inob = 4'($urandom);
            ordy = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        ivld = 1'b0;
        drain();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
